// File: rtl/quiz_round_arbiter.sv
// Round controller for the two-player quiz: synchronises the active-low remotes,
// arbitrates presses with per-player lockout, keeps scores and drives the display phases.
module quiz_round_arbiter #(
    parameter int N_QUESTIONS = 10,
    parameter int WIN_SCORE   = 5,
    parameter int LOCKOUT_CYC = 8,
    parameter int SHOW_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_hex,
    input  logic [3:0] ans,
    input  logic       start,
    output logic [3:0] q_idx,
    output logic [2:0] score_p1,
    output logic [2:0] score_p2,
    output logic       lock_p1,
    output logic       lock_p2,
    output logic [1:0] result,
    output logic [1:0] winner,
    output logic       beep
);

    localparam int LCK_W = $clog2(LOCKOUT_CYC + 1);
    localparam int SHW_W = $clog2(SHOW_CYC + 1);
    localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYC);
    localparam logic [LCK_W-1:0] LCK_ONE  = LCK_W'(1);
    localparam logic [SHW_W-1:0] SHW_LOAD = SHW_W'(SHOW_CYC);
    localparam logic [SHW_W-1:0] SHW_ONE  = SHW_W'(1);
    localparam logic [2:0]       WIN_V    = 3'(WIN_SCORE);
    localparam logic [3:0]       Q_LAST   = 4'(N_QUESTIONS - 1);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        SHOW  = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [3:0]       q_idx_q, q_idx_d;
    logic [2:0]       score1_q, score1_d, score2_q, score2_d;
    logic             lock1_q, lock1_d, lock2_q, lock2_d;
    logic [LCK_W-1:0] lcnt1_q, lcnt1_d, lcnt2_q, lcnt2_d;
    logic [SHW_W-1:0] show_cnt_q, show_cnt_d;
    logic [1:0]       result_q, result_d, winner_q, winner_d;
    logic             beep_q, beep_d;

    logic [7:0]       low_n;
    logic [3:0]       pick;
    logic [3:0]       choice;
    logic             one_low, ev, ev_p1, correct, p1_try, p2_try;

    function automatic logic [2:0] sat_inc(input logic [2:0] s);
        return (s >= WIN_V) ? s : s + 3'd1;
    endfunction

    // Press decode: the v* flags make sure the "released" sample is a real one, not the reset fill
    always_comb begin
        low_n   = ~s2_q;
        one_low = (low_n != 8'h00) && ((low_n & (low_n - 8'd1)) == 8'h00);
        ev      = v3_q && (s3_q == 8'hFF) && one_low;
        ev_p1   = |low_n[7:4];
        pick    = ev_p1 ? low_n[7:4] : low_n[3:0];
        if (pick[3])      choice = 4'd1;
        else if (pick[2]) choice = 4'd2;
        else if (pick[1]) choice = 4'd3;
        else              choice = 4'd4;
        correct = (choice == ans);
        p1_try  = ev && ev_p1 && !lock1_q;
        p2_try  = ev && !ev_p1 && !lock2_q;
    end

    always_comb begin
        s1_d       = in_hex;
        s2_d       = s1_q;
        s3_d       = s2_q;
        v1_d       = 1'b1;
        v2_d       = v1_q;
        v3_d       = v2_q;
        state_d    = state_q;
        q_idx_d    = q_idx_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        show_cnt_d = show_cnt_q;
        result_d   = result_q;
        winner_d   = winner_q;
        beep_d     = beep_q;
        lock1_d    = lock1_q;
        lcnt1_d    = lcnt1_q;
        lock2_d    = lock2_q;
        lcnt2_d    = lcnt2_q;

        // Lockout timers run in every state; the lock drops on the edge the count hits zero
        if (lcnt1_q != '0) begin
            lcnt1_d = lcnt1_q - LCK_ONE;
            lock1_d = (lcnt1_q != LCK_ONE);
        end
        if (lcnt2_q != '0) begin
            lcnt2_d = lcnt2_q - LCK_ONE;
            lock2_d = (lcnt2_q != LCK_ONE);
        end

        case (state_q)
            ARMED: begin
                if (p1_try) begin
                    if (correct) begin
                        score1_d   = sat_inc(score1_q);
                        result_d   = 2'd1;
                        show_cnt_d = SHW_LOAD;
                        beep_d     = 1'b1;
                        state_d    = SHOW;
                    end else begin
                        lock1_d = 1'b1;
                        lcnt1_d = LCK_LOAD;
                    end
                end else if (p2_try) begin
                    if (correct) begin
                        score2_d   = sat_inc(score2_q);
                        result_d   = 2'd2;
                        show_cnt_d = SHW_LOAD;
                        beep_d     = 1'b1;
                        state_d    = SHOW;
                    end else begin
                        lock2_d = 1'b1;
                        lcnt2_d = LCK_LOAD;
                    end
                end
            end
            SHOW: begin
                if (show_cnt_q <= SHW_ONE) begin
                    show_cnt_d = '0;
                    result_d   = 2'd0;
                    if ((result_q == 2'd1 && score1_q == WIN_V) ||
                        (result_q == 2'd2 && score2_q == WIN_V)) begin
                        winner_d = result_q;
                        state_d  = OVER;
                    end else begin
                        q_idx_d = (q_idx_q == Q_LAST) ? 4'd0 : q_idx_q + 4'd1;
                        lock1_d = 1'b0;
                        lcnt1_d = '0;
                        lock2_d = 1'b0;
                        lcnt2_d = '0;
                        beep_d  = 1'b0;
                        state_d = ARMED;
                    end
                end else begin
                    show_cnt_d = show_cnt_q - SHW_ONE;
                end
            end
            OVER: begin
                if (start) begin
                    q_idx_d    = 4'd0;
                    score1_d   = 3'd0;
                    score2_d   = 3'd0;
                    winner_d   = 2'd0;
                    result_d   = 2'd0;
                    lock1_d    = 1'b0;
                    lcnt1_d    = '0;
                    lock2_d    = 1'b0;
                    lcnt2_d    = '0;
                    show_cnt_d = '0;
                    beep_d     = 1'b0;
                    state_d    = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARMED;
            s1_q       <= 8'hFF;
            s2_q       <= 8'hFF;
            s3_q       <= 8'hFF;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            v3_q       <= 1'b0;
            q_idx_q    <= 4'd0;
            score1_q   <= 3'd0;
            score2_q   <= 3'd0;
            lock1_q    <= 1'b0;
            lock2_q    <= 1'b0;
            lcnt1_q    <= '0;
            lcnt2_q    <= '0;
            show_cnt_q <= '0;
            result_q   <= 2'd0;
            winner_q   <= 2'd0;
            beep_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            v3_q       <= v3_d;
            q_idx_q    <= q_idx_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            lock1_q    <= lock1_d;
            lock2_q    <= lock2_d;
            lcnt1_q    <= lcnt1_d;
            lcnt2_q    <= lcnt2_d;
            show_cnt_q <= show_cnt_d;
            result_q   <= result_d;
            winner_q   <= winner_d;
            beep_q     <= beep_d;
        end
    end

    assign q_idx    = q_idx_q;
    assign score_p1 = score1_q;
    assign score_p2 = score2_q;
    assign lock_p1  = lock1_q;
    assign lock_p2  = lock2_q;
    assign result   = result_q;
    assign winner   = winner_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_quiz_round_arbiter.sv
// Directed bench for quiz_round_arbiter: a game-level model checked every cycle,
// plus literal expectations at the key moments of each scenario.
module tb_quiz_round_arbiter;

    localparam int TB_N    = 10;
    localparam int TB_WIN  = 7;   // raised so ten advances fit inside one game
    localparam int TB_LOCK = 8;
    localparam int TB_SHOW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] in_hex = 8'hFF;
    logic [3:0] ans = 4'd0;
    logic       start = 1'b0;
    logic [3:0] q_idx;
    logic [2:0] score_p1, score_p2;
    logic       lock_p1, lock_p2;
    logic [1:0] result, winner;
    logic       beep;

    quiz_round_arbiter #(
        .N_QUESTIONS(TB_N),
        .WIN_SCORE  (TB_WIN),
        .LOCKOUT_CYC(TB_LOCK),
        .SHOW_CYC   (TB_SHOW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_hex  (in_hex),
        .ans     (ans),
        .start   (start),
        .q_idx   (q_idx),
        .score_p1(score_p1),
        .score_p2(score_p2),
        .lock_p1 (lock_p1),
        .lock_p2 (lock_p2),
        .result  (result),
        .winner  (winner),
        .beep    (beep)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Game model: edge counter, sample history since reset, deadlines instead of counters
    int         cyc;
    int         mstate;          // 0 armed, 1 showing, 2 game over
    int         m_q, m_res, m_win, show_start;
    int         m_s[2];
    int         lock_until[2];
    logic [7:0] hist[$];

    function automatic int m_lock(input int p);
        return (lock_until[p] > cyc) ? 1 : 0;
    endfunction

    task automatic m_reset();
        cyc = -1;
        mstate = 0;
        m_q = 0;
        m_res = 0;
        m_win = 0;
        show_start = 0;
        m_s[0] = 0;
        m_s[1] = 0;
        lock_until[0] = -1;
        lock_until[1] = -1;
        hist.delete();
    endtask

    task automatic m_step();
        int n, lows, bitpos, pl, ch;
        bit ev;
        cyc++;
        n = hist.size();
        ev = 0;
        pl = 0;
        ch = 0;
        if (n >= 3 && hist[n-3] == 8'hFF) begin
            lows = 0;
            bitpos = 0;
            for (int b = 0; b < 8; b++) begin
                if (!hist[n-2][b]) begin
                    lows++;
                    bitpos = b;
                end
            end
            if (lows == 1) begin
                ev = 1;
                pl = (bitpos >= 4) ? 0 : 1;
                ch = 4 - (bitpos % 4);
            end
        end
        hist.push_back(in_hex);
        case (mstate)
            0: begin
                if (ev && !(lock_until[pl] > cyc - 1)) begin
                    if (ch == int'(ans)) begin
                        if (m_s[pl] < TB_WIN) m_s[pl]++;
                        m_res = pl + 1;
                        show_start = cyc;
                        mstate = 1;
                    end else begin
                        lock_until[pl] = cyc + TB_LOCK;
                    end
                end
            end
            1: begin
                if (cyc - show_start == TB_SHOW) begin
                    if (m_s[m_res-1] == TB_WIN) begin
                        m_win = m_res;
                        mstate = 2;
                    end else begin
                        m_q = (m_q + 1) % TB_N;
                        lock_until[0] = -1;
                        lock_until[1] = -1;
                        mstate = 0;
                    end
                    m_res = 0;
                end
            end
            default: begin
                if (start) begin
                    m_q = 0;
                    m_s[0] = 0;
                    m_s[1] = 0;
                    m_win = 0;
                    m_res = 0;
                    lock_until[0] = -1;
                    lock_until[1] = -1;
                    mstate = 0;
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("q_idx",    q_idx,    m_q);
            chk("score_p1", score_p1, m_s[0]);
            chk("score_p2", score_p2, m_s[1]);
            chk("lock_p1",  lock_p1,  m_lock(0));
            chk("lock_p2",  lock_p2,  m_lock(1));
            chk("result",   result,   m_res);
            chk("winner",   winner,   m_win);
            chk("beep",     beep,     (mstate != 0) ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v, input logic [3:0] a);
        ans = a;
        in_hex = v;
        tick();
        in_hex = 8'hFF;
        repeat (9) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q_idx"}, q_idx, 0);
        chk({tag, "_score_p1"}, score_p1, 0);
        chk({tag, "_score_p2"}, score_p2, 0);
        chk({tag, "_locks"}, {lock_p1, lock_p2}, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_winner"}, winner, 0);
        chk({tag, "_beep"}, beep, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (4) tick();

        // Correct P1 press, choice 2
        ans = 4'd2;
        in_hex = 8'hBF;
        tick();
        tick();
        chk("t1_score_before", score_p1, 0);
        tick();
        chk("t1_score_after", score_p1, 1);
        chk("t1_result", result, 1);
        chk("t1_beep", beep, 1);
        tick();
        tick();
        in_hex = 8'hFF;
        tick();
        chk("t1_show_last", result, 1);
        chk("t1_q_hold", q_idx, 0);
        tick();
        chk("t1_q_adv", q_idx, 1);
        chk("t1_beep_off", beep, 0);
        repeat (3) tick();

        // Wrong P2 answer, P2 retry while locked, P1 scores meanwhile
        ans = 4'd3;
        in_hex = 8'hFE;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        chk("t2_lock_set", lock_p2, 1);
        chk("t2_score_p2", score_p2, 0);
        in_hex = 8'hFD;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        chk("t2_locked_ignored", score_p2, 0);
        chk("t2_lock_held", lock_p2, 1);
        in_hex = 8'hDF;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        chk("t2_p1_scores", score_p1, 2);
        chk("t2_p1_result", result, 1);
        tick();
        chk("t2_lock_cycle8", lock_p2, 1);
        tick();
        chk("t2_lock_clear", lock_p2, 0);
        repeat (4) tick();
        chk("t2_q", q_idx, 2);

        // Both players low in one sample
        ans = 4'd1;
        in_hex = 8'h7E;
        tick();
        in_hex = 8'hFF;
        repeat (6) tick();
        chk("t3_p1", score_p1, 2);
        chk("t3_p2", score_p2, 0);
        chk("t3_locks", {lock_p1, lock_p2}, 0);
        chk("t3_beep", beep, 0);

        // Alternate scorers across the question wrap
        for (int i = 0; i < 8; i++) begin
            if (i == 7) chk("t5_q_before_wrap", q_idx, 9);
            if (i % 2 == 0) press(8'hF7, 4'd1);
            else            press(8'h7F, 4'd1);
        end
        chk("t5_q_wrapped", q_idx, 0);
        chk("t5_p1", score_p1, 6);
        chk("t5_p2", score_p2, 4);

        // Game to the win, presses frozen in OVER, then restart
        press(8'hFB, 4'd2);
        press(8'h7F, 4'd1);
        chk("t4_winner", winner, 1);
        chk("t4_score", score_p1, TB_WIN);
        chk("t4_beep", beep, 1);
        chk("t4_result", result, 0);
        chk("t4_q_frozen", q_idx, 1);
        press(8'hF7, 4'd1);
        chk("t4_over_ignore", score_p2, 5);
        chk("t4_over_q", q_idx, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all_zero("restart");
        repeat (2) tick();

        // start during SHOW does nothing
        ans = 4'd1;
        in_hex = 8'h7F;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        chk("t6_show", result, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        chk("t6_score", score_p1, 1);
        chk("t6_q", q_idx, 1);

        // Reset in the middle of SHOW with a press held through deassertion
        in_hex = 8'h7F;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        tick();
        chk("t7_pre_reset", score_p1, 2);
        rst_n = 1'b0;
        in_hex = 8'h7F;
        #1;
        chk_all_zero("midshow_reset");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("t7_held_no_event", score_p1, 0);
        in_hex = 8'hFF;
        tick();
        in_hex = 8'h7F;
        tick();
        in_hex = 8'hFF;
        tick();
        tick();
        chk("t7_after_release", score_p1, 1);
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
